// File: rtl/slurm32_pkg.sv
// Shared constants for the slurm32 write-back stage: opcode classes, the
// interrupt link register index and the load byte-lane masks.
package slurm32_pkg;

  // Opcode class lives in instruction[31:28].
  typedef enum logic [3:0] {
    OpClassNop        = 4'h0,
    OpClassBranchLink = 4'h1,
    OpClassAluReg     = 4'h2,
    OpClassAluImm     = 4'h3,
    OpClassLoad       = 4'h4
  } op_class_e;

  typedef enum logic [1:0] {
    SrcAlu,
    SrcMem,
    SrcPc,
    SrcLink
  } wb_src_e;

  localparam logic [7:0] ILINK_REG = 8'hFE;

  localparam logic [3:0] MASK_WORD  = 4'b1111;
  localparam logic [3:0] MASK_HALF0 = 4'b0011;
  localparam logic [3:0] MASK_HALF1 = 4'b1100;
  localparam logic [3:0] MASK_BYTE0 = 4'b0001;
  localparam logic [3:0] MASK_BYTE1 = 4'b0010;
  localparam logic [3:0] MASK_BYTE2 = 4'b0100;
  localparam logic [3:0] MASK_BYTE3 = 4'b1000;

endpackage

// File: rtl/slurm32_wb_load_align.sv
// Aligns and zero-extends a load word according to its byte-lane mask.
module slurm32_wb_load_align
  import slurm32_pkg::*;
(
  input  logic [31:0] memory_in,
  input  logic [3:0]  mask,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = memory_in;
    case (mask)
      MASK_WORD:  data_o = memory_in;
      MASK_HALF0: data_o = {16'h0000, memory_in[15:0]};
      MASK_HALF1: data_o = {16'h0000, memory_in[31:16]};
      MASK_BYTE0: data_o = {24'h000000, memory_in[7:0]};
      MASK_BYTE1: data_o = {24'h000000, memory_in[15:8]};
      MASK_BYTE2: data_o = {24'h000000, memory_in[23:16]};
      MASK_BYTE3: data_o = {24'h000000, memory_in[31:24]};
      // Irregular masks fall back to the full word.
      default:    data_o = memory_in;
    endcase
  end

endmodule

// File: rtl/slurm32_cpu_writeback.sv
// Write-back stage: selects destination register and data for the slot-4
// instruction. Purely combinational apart from the registered reset.
module slurm32_cpu_writeback
  import slurm32_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] instruction,
  input  logic [31:0] aluOut,
  input  logic [31:0] memory_in,
  output logic [7:0]  reg_wr_sel,
  output logic [31:0] reg_out,
  input  logic [31:0] pc_stage4,
  input  logic [3:0]  memory_mask_delayed,
  input  logic        nop_stage4,
  input  logic        load_interrupt_return_address,
  input  logic        cond_pass
);

  logic        rst_d, rst_q;
  logic [3:0]  op_class;
  logic [7:0]  rd;
  logic        wr_en;
  wb_src_e     src;
  logic [31:0] load_data;
  logic [31:0] link_addr;
  logic [19:0] unused_instr;

  assign unused_instr = {instruction[27:24], instruction[15:0]};

  always_comb rst_d = RST;

  always_ff @(posedge CLK) begin
    rst_q <= rst_d;
  end

  slurm32_wb_load_align u_load_align (
    .memory_in (memory_in),
    .mask      (memory_mask_delayed),
    .data_o    (load_data)
  );

  assign link_addr = pc_stage4 + 32'd4;

  always_comb begin
    op_class = instruction[31:28];
    rd       = instruction[23:16];
    wr_en    = 1'b0;
    src      = SrcAlu;

    case (op_class)
      OpClassAluReg, OpClassAluImm: wr_en = 1'b1;
      OpClassLoad: begin
        wr_en = 1'b1;
        src   = SrcMem;
      end
      OpClassBranchLink: begin
        if (cond_pass) begin
          wr_en = 1'b1;
          src   = SrcLink;
        end
      end
      default: wr_en = 1'b0;
    endcase

    // Interrupt return-address write beats both NOP and decode.
    if (load_interrupt_return_address) begin
      reg_wr_sel = ILINK_REG;
      src        = SrcPc;
    end else if (nop_stage4 || !wr_en) begin
      reg_wr_sel = 8'h00;
    end else begin
      reg_wr_sel = rd;
    end

    if (rst_q) begin
      reg_wr_sel = 8'h00;
    end

    case (src)
      SrcMem:  reg_out = load_data;
      SrcPc:   reg_out = pc_stage4;
      SrcLink: reg_out = link_addr;
      default: reg_out = aluOut;
    endcase
  end

endmodule

// File: tb/tb_slurm32_cpu_writeback.sv
// Self-checking bench for slurm32_cpu_writeback: reset sequence plus a vector
// table scored through an expectation queue.
module tb_slurm32_cpu_writeback;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] instruction, aluOut, memory_in, pc_stage4;
  logic [7:0]  reg_wr_sel;
  logic [31:0] reg_out;
  logic [3:0]  memory_mask_delayed;
  logic        nop_stage4, load_interrupt_return_address, cond_pass;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  slurm32_cpu_writeback dut (
    .CLK                           (CLK),
    .RST                           (RST),
    .instruction                   (instruction),
    .aluOut                        (aluOut),
    .memory_in                     (memory_in),
    .reg_wr_sel                    (reg_wr_sel),
    .reg_out                       (reg_out),
    .pc_stage4                     (pc_stage4),
    .memory_mask_delayed           (memory_mask_delayed),
    .nop_stage4                    (nop_stage4),
    .load_interrupt_return_address (load_interrupt_return_address),
    .cond_pass                     (cond_pass)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [3:0]  mask;
    logic        nop;
    logic        irq;
    logic        cond;
    logic [7:0]  sel;
    logic [31:0] out;
    logic        chk_out;
  } vec_t;

  typedef struct {
    string       name;
    logic [7:0]  sel;
    logic [31:0] out;
    logic        chk_out;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(string name, logic [31:0] instr, logic [31:0] alu,
                              logic [31:0] mem, logic [31:0] pc, logic [3:0] mask,
                              logic nop, logic irq, logic cond, logic [7:0] sel,
                              logic [31:0] out, logic chk_out);
    vec_t v;
    v.name = name; v.instr = instr; v.alu = alu; v.mem = mem; v.pc = pc;
    v.mask = mask; v.nop = nop; v.irq = irq; v.cond = cond;
    v.sel = sel; v.out = out; v.chk_out = chk_out;
    return v;
  endfunction

  task automatic drive(vec_t v);
    exp_t e;
    instruction = v.instr; aluOut = v.alu; memory_in = v.mem; pc_stage4 = v.pc;
    memory_mask_delayed = v.mask; nop_stage4 = v.nop;
    load_interrupt_return_address = v.irq; cond_pass = v.cond;
    e.name = v.name; e.sel = v.sel; e.out = v.out; e.chk_out = v.chk_out;
    sb.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (reg_wr_sel !== e.sel) begin
      errors++;
      $display("FAIL %s sel: got %02h expected %02h", e.name, reg_wr_sel, e.sel);
    end
    if (e.chk_out) begin
      checks++;
      if (reg_out !== e.out) begin
        errors++;
        $display("FAIL %s out: got %08h expected %08h", e.name, reg_out, e.out);
      end
    end
  endtask

  localparam logic [31:0] ADD = 32'h21030405;
  localparam logic [31:0] AA  = 32'haa55aa55;
  localparam logic [31:0] DB  = 32'hdeadbeef;
  localparam logic [31:0] LD7 = 32'h40070000;

  initial begin
    vecs.push_back(mk("add",        ADD, AA, DB, 0, 4'b1111, 0, 0, 0, 8'h03, AA, 1));
    vecs.push_back(mk("add_nop",    ADD, AA, DB, 0, 4'b1111, 1, 0, 0, 8'h00, AA, 1));
    vecs.push_back(mk("ld_b2",      LD7, AA, DB, 0, 4'b0100, 0, 0, 0, 8'h07, 32'h000000ad, 1));
    vecs.push_back(mk("ld_h1",      LD7, AA, DB, 0, 4'b1100, 0, 0, 0, 8'h07, 32'h0000dead, 1));
    vecs.push_back(mk("ld_w",       LD7, AA, DB, 0, 4'b1111, 0, 0, 0, 8'h07, DB, 1));
    vecs.push_back(mk("ld_h0",      LD7, AA, DB, 0, 4'b0011, 0, 0, 0, 8'h07, 32'h0000beef, 1));
    vecs.push_back(mk("ld_b0",      LD7, AA, DB, 0, 4'b0001, 0, 0, 0, 8'h07, 32'h000000ef, 1));
    vecs.push_back(mk("ld_b1",      LD7, AA, DB, 0, 4'b0010, 0, 0, 0, 8'h07, 32'h000000be, 1));
    vecs.push_back(mk("ld_b3",      LD7, AA, DB, 0, 4'b1000, 0, 0, 0, 8'h07, 32'h000000de, 1));
    vecs.push_back(mk("ld_odd",     LD7, AA, DB, 0, 4'b0101, 0, 0, 0, 8'h07, DB, 1));
    vecs.push_back(mk("ld_4f_nop",  32'h4f0a0000, AA, DB, 0, 4'b0001, 1, 0, 0, 8'h00,
                      32'h000000ef, 1));
    vecs.push_back(mk("bl_pass",    32'h1f0f0000, AA, DB, 32'h100, 4'b1111, 0, 0, 1, 8'h0f,
                      32'h104, 1));
    vecs.push_back(mk("bl_fail",    32'h1f0f0000, AA, DB, 32'h100, 4'b1111, 0, 0, 0, 8'h00,
                      0, 0));
    vecs.push_back(mk("bl_wrap",    32'h10010000, AA, DB, 32'hfffffffc, 4'b1111, 0, 0, 1,
                      8'h01, 32'h00000000, 1));
    vecs.push_back(mk("irq_nop",    ADD, AA, DB, 32'h200, 4'b1111, 1, 1, 0, 8'hfe, 32'h200, 1));
    vecs.push_back(mk("irq_ld",     LD7, AA, DB, 32'h344, 4'b0001, 0, 1, 1, 8'hfe, 32'h344, 1));
    vecs.push_back(mk("aluimm",     32'h3a090000, 32'h12345678, DB, 0, 4'b1111, 0, 0, 0, 8'h09,
                      32'h12345678, 1));
    vecs.push_back(mk("alu_2f",     32'h2f050000, 32'h0badf00d, DB, 0, 4'b1111, 0, 0, 1, 8'h05,
                      32'h0badf00d, 1));
    vecs.push_back(mk("rd0",        32'h20000000, AA, DB, 0, 4'b1111, 0, 0, 0, 8'h00, AA, 1));
    vecs.push_back(mk("nop_op",     32'h00070000, AA, DB, 0, 4'b1111, 0, 0, 1, 8'h00, AA, 1));
    vecs.push_back(mk("store",      32'h50070000, AA, DB, 0, 4'b1111, 0, 0, 1, 8'h00, AA, 1));
    vecs.push_back(mk("op_0f",      32'h0f070000, AA, DB, 0, 4'b1111, 0, 0, 1, 8'h00, AA, 1));

    // Reset sequence with an add held on the inputs.
    RST = 1'b1;
    drive(vecs[0]);
    void'(sb.pop_back());
    @(posedge CLK); @(posedge CLK); @(negedge CLK);
    sb.push_back('{name: "rst_held", sel: 8'h00, out: AA, chk_out: 1'b1});
    #1 score();
    RST = 1'b0;
    sb.push_back('{name: "rst_released_pre_edge", sel: 8'h00, out: AA, chk_out: 1'b0});
    #1 score();
    @(posedge CLK); #1;
    sb.push_back('{name: "rst_released_post_edge", sel: 8'h03, out: AA, chk_out: 1'b1});
    score();

    foreach (vecs[i]) begin
      @(negedge CLK);
      drive(vecs[i]);
      #1 score();
    end

    // Reset reasserted mid-stream with a load: write suppressed, data still aligned.
    @(negedge CLK);
    RST = 1'b1;
    drive(vecs[2]);
    @(posedge CLK); #1;
    sb.pop_back();
    sb.push_back('{name: "rst_mid_load", sel: 8'h00, out: 32'h000000ad, chk_out: 1'b1});
    score();
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    sb.push_back('{name: "rst_mid_release", sel: 8'h07, out: 32'h000000ad, chk_out: 1'b1});
    score();

    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slurm32_cpu_writeback.md
SLURM32_CPU_WRITEBACK -- requirements
Module: slurm32_cpu_writeback

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single pipeline clock.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port instruction, input, 32 bits: the instruction in pipeline slot 4.
REQ-004 SHALL have port aluOut, input, 32 bits: the ALU result for the slot-4 instruction.
REQ-005 SHALL have port memory_in, input, 32 bits: the load data word returned from memory.
REQ-006 SHALL have port reg_wr_sel, output, 8 bits: write-back register index; 0 means no write.
REQ-007 SHALL have port reg_out, output, 32 bits: write-back data.
REQ-008 SHALL have port pc_stage4, input, 32 bits: the PC of the slot-4 instruction.
REQ-009 SHALL have port memory_mask_delayed, input, 4 bits: byte-lane mask of the load, where bit n is byte n.
REQ-010 SHALL have port nop_stage4, input, 1 bit: the slot-4 instruction is NOP'd out.
REQ-011 SHALL have port load_interrupt_return_address, input, 1 bit: an interrupt is taken and the return address must be written.
REQ-012 SHALL have port cond_pass, input, 1 bit: the branch condition evaluated in stage 2 passed.

Function
REQ-013 SHALL be purely combinational from the data inputs to reg_wr_sel and reg_out, with zero-cycle latency; CLK is used only for reset sampling.
REQ-014 SHALL decode the opcode class from instruction[31:24] and the destination register rd from instruction[23:16].
REQ-015 Classes 0x20-0x2F (ALU reg-reg) and 0x30-0x3F (ALU reg-imm) SHALL set reg_wr_sel=rd and reg_out=aluOut, independent of cond_pass.
REQ-016 Classes 0x40-0x4F (loads) SHALL set reg_wr_sel=rd and reg_out=aligned, zero-extended memory_in, selected by the mask:
- 1111 -> the full word.
- 0011 -> memory_in[15:0].
- 1100 -> memory_in[31:16].
- 0001 -> byte 0; 0010 -> byte 1; 0100 -> byte 2; 1000 -> byte 3.
- Any other mask -> the full word.
REQ-017 Classes 0x10-0x1F (branch-and-link) SHALL set reg_wr_sel=rd and reg_out=pc_stage4+4 when cond_pass=1; when cond_pass=0 they SHALL set reg_wr_sel=0.
REQ-018 All other opcodes (NOP 0x00, stores, plain branches, undefined) SHALL set reg_wr_sel=0.
REQ-019 nop_stage4=1 SHALL force reg_wr_sel=0 while leaving the reg_out data mux unchanged (an add still presents aluOut).
REQ-020 load_interrupt_return_address=1 SHALL override nop_stage4 and the decode, setting reg_wr_sel=8'hFE (interrupt link register) and reg_out=pc_stage4.
REQ-021 When no write occurs and no other source is selected, reg_out SHALL default to aluOut.
REQ-022 rd=0 SHALL pass through unchanged; r0 is hard-wired zero in the register file.
REQ-023 The 32-bit PC addition SHALL wrap modulo 2^32.

Reset
REQ-024 RST SHALL be registered on the CLK rising edge; while the registered reset is high, reg_wr_sel SHALL be 0 and reg_out SHALL still follow the mux.
REQ-025 SHALL have no other state; after reset deasserts, outputs SHALL be valid on the next edge with no flush.

Structure
REQ-026 The shared package slurm32_pkg SHALL hold the opcode class constants, the ILINK_REG index (8'hFE) and the byte-mask constants.
REQ-027 Load alignment SHALL be a single sub-module, slurm32_wb_load_align (memory_in, mask -> 32-bit data).

Verification
REQ-028 instruction=0x21030405 (add r3,r4,r5), aluOut=0xaa55aa55, memory_in=0xdeadbeef, nop=0, cond_pass=0 -> reg_wr_sel=0x03, reg_out=0xaa55aa55.
REQ-029 Same inputs with nop_stage4=1 -> reg_wr_sel=0x00, reg_out=0xaa55aa55.
REQ-030 Load rd=7, memory_in=0xdeadbeef, mask=0100 -> reg_wr_sel=0x07, reg_out=0x000000ad; mask=1100 -> reg_out=0x0000dead.
REQ-031 Branch-and-link rd=15, pc_stage4=0x100, cond_pass=1 -> reg_wr_sel=0x0F, reg_out=0x104; cond_pass=0 -> reg_wr_sel=0.
REQ-032 load_interrupt_return_address=1, nop_stage4=1, pc_stage4=0x200 -> reg_wr_sel=0xFE, reg_out=0x200.
REQ-033 RST=1 across a clock edge with an add -> reg_wr_sel=0; after RST=0 and the next edge -> reg_wr_sel=rd.
